// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FPU datapath blocks.
// Holds the rounding-mode and divider-state encodings, binary32 constants
// and operand class-decode helpers (shared with the multiplier).
package fp_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } r_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [9:0]  BIAS       = 10'd127;
  localparam logic [31:0] QNAN       = 32'h7FC00000;
  localparam logic [31:0] POS_INF    = 32'h7F800000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7FFFFF;
  localparam logic [4:0]  ITER_LAST  = 5'd25;

  // Zero class: subnormals are flushed, so any zero exponent counts.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/fp_div_round.sv
// Combinational rounding / packing stage of the divider.
// Ports: sign, e (10-bit signed biased exponent), man (24-bit mantissa with
// hidden bit), guard, sticky, r_mode in; z (packed binary32), ovrf, udrf out.
module fp_div_round
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] e,
  input  logic [23:0]       man,
  input  logic              guard,
  input  logic              sticky,
  input  logic [2:0]        r_mode,
  output logic [31:0]       z,
  output logic              ovrf,
  output logic              udrf
);

  logic              inc_s;
  logic [24:0]       man_sum_s;
  logic signed [9:0] e_fin_s;
  logic [22:0]       frac_s;

  // Round-increment decision per rounding mode; unused encodings act as RNE.
  always_comb begin
    inc_s = 1'b0;
    case (r_mode)
      RTZ:     inc_s = 1'b0;
      RDN:     inc_s = sign & (guard | sticky);
      RUP:     inc_s = ~sign & (guard | sticky);
      RMM:     inc_s = guard;
      default: inc_s = guard & (sticky | man[0]);
    endcase
  end

  // Apply increment; a carry out of the mantissa means exactly 2.0, so
  // renormalise to 1.0 and bump the exponent.
  always_comb begin
    man_sum_s = {1'b0, man} + {24'd0, inc_s};
    e_fin_s   = e + {9'd0, man_sum_s[24]};
    if (man_sum_s[24]) begin
      frac_s = man_sum_s[23:1];
    end else begin
      frac_s = man_sum_s[22:0];
    end
  end

  // Range check and final packing, including mode-dependent overflow saturation.
  always_comb begin
    z    = 32'd0;
    ovrf = 1'b0;
    udrf = 1'b0;
    if (e_fin_s >= 10'sd255) begin
      ovrf = 1'b1;
      case (r_mode)
        RTZ:     z = {sign, MAX_FINITE[30:0]};
        RDN:     z = sign ? {1'b1, POS_INF[30:0]} : {1'b0, MAX_FINITE[30:0]};
        RUP:     z = sign ? {1'b1, MAX_FINITE[30:0]} : {1'b0, POS_INF[30:0]};
        default: z = {sign, POS_INF[30:0]};
      endcase
    end else if (e_fin_s <= 10'sd0) begin
      udrf = 1'b1;
      z    = {sign, 31'd0};
    end else begin
      z = {sign, e_fin_s[7:0], frac_s};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: fp_Z = fp_X / fp_Y using a radix-2 restoring
// mantissa divider (one quotient bit per cycle), subnormals flushed to zero.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with fp_X, fp_Y,
// r_mode; out_valid/out_ready with fp_Z and flags ovrf, udrf, dz.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        dz
);

  state_t            state_r;
  logic              sign_r;
  logic [2:0]        rmode_r;
  logic [23:0]       div_r;
  logic [25:0]       rem_r;
  logic [25:0]       quo_r;
  logic signed [9:0] exp_r;
  logic [4:0]        cnt_r;

  logic              sign_s;
  logic              spec_hit_s;
  logic [31:0]       spec_z_s;
  logic              spec_dz_s;
  logic [26:0]       diff_s;
  logic              ge_s;
  logic [25:0]       rem_sel_s;
  logic [23:0]       man_s;
  logic              guard_s;
  logic              sticky_s;
  logic signed [9:0] exp_adj_s;
  logic [31:0]       rnd_z_s;
  logic              rnd_ovrf_s;
  logic              rnd_udrf_s;

  assign sign_s = fp_X[31] ^ fp_Y[31];

  // Special-operand decode on the incoming operands, in priority order.
  always_comb begin
    spec_hit_s = 1'b1;
    spec_z_s   = 32'd0;
    spec_dz_s  = 1'b0;
    if (is_nan(fp_X) || is_nan(fp_Y) || (is_zero(fp_X) && is_zero(fp_Y)) ||
        (is_inf(fp_X) && is_inf(fp_Y))) begin
      spec_z_s = QNAN;
    end else if (is_inf(fp_X)) begin
      spec_z_s = {sign_s, POS_INF[30:0]};
    end else if (is_inf(fp_Y)) begin
      spec_z_s = {sign_s, 31'd0};
    end else if (is_zero(fp_Y)) begin
      spec_z_s  = {sign_s, POS_INF[30:0]};
      spec_dz_s = 1'b1;
    end else if (is_zero(fp_X)) begin
      spec_z_s = {sign_s, 31'd0};
    end else begin
      spec_hit_s = 1'b0;
    end
  end

  // One restoring step: the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    diff_s = {1'b0, rem_r} - {3'b000, div_r};
    ge_s   = ~diff_s[26];
    if (ge_s) begin
      rem_sel_s = diff_s[25:0];
    end else begin
      rem_sel_s = rem_r;
    end
  end

  // Normalise the quotient: q[25] set means the ratio is in [1,2).
  always_comb begin
    if (quo_r[25]) begin
      man_s     = quo_r[25:2];
      guard_s   = quo_r[1];
      sticky_s  = quo_r[0] | (rem_r != 26'd0);
      exp_adj_s = exp_r;
    end else begin
      man_s     = quo_r[24:1];
      guard_s   = quo_r[0];
      sticky_s  = (rem_r != 26'd0);
      exp_adj_s = exp_r - 10'sd1;
    end
  end

  fp_div_round u_round (
    .sign   (sign_r),
    .e      (exp_adj_s),
    .man    (man_s),
    .guard  (guard_s),
    .sticky (sticky_s),
    .r_mode (rmode_r),
    .z      (rnd_z_s),
    .ovrf   (rnd_ovrf_s),
    .udrf   (rnd_udrf_s)
  );

  // Control FSM with datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      fp_Z      <= 32'd0;
      ovrf      <= 1'b0;
      udrf      <= 1'b0;
      dz        <= 1'b0;
      cnt_r     <= 5'd0;
      sign_r    <= 1'b0;
      rmode_r   <= 3'd0;
      div_r     <= 24'd0;
      rem_r     <= 26'd0;
      quo_r     <= 26'd0;
      exp_r     <= 10'sd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            sign_r   <= sign_s;
            rmode_r  <= r_mode;
            if (spec_hit_s) begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              fp_Z      <= spec_z_s;
              dz        <= spec_dz_s;
              ovrf      <= 1'b0;
              udrf      <= 1'b0;
            end else begin
              state_r <= CALC;
              rem_r   <= {3'b001, fp_X[22:0]};
              div_r   <= {1'b1, fp_Y[22:0]};
              quo_r   <= 26'd0;
              cnt_r   <= ITER_LAST;
              // Two's-complement wrap gives the signed 10-bit result directly.
              exp_r   <= signed'({2'b00, fp_X[30:23]} - {2'b00, fp_Y[30:23]} + BIAS);
            end
          end
        end
        CALC: begin
          quo_r <= {quo_r[24:0], ge_s};
          rem_r <= rem_sel_s << 1;
          if (cnt_r == 5'd0) begin
            state_r <= ROUND;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        ROUND: begin
          state_r   <= DONE;
          out_valid <= 1'b1;
          fp_Z      <= rnd_z_s;
          ovrf      <= rnd_ovrf_s;
          udrf      <= rnd_udrf_s;
          dz        <= 1'b0;
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            fp_Z      <= 32'd0;
            ovrf      <= 1'b0;
            udrf      <= 1'b0;
            dz        <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
